// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack,
// feeds the IR with a one-entry skid buffer and redirect kill.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ir_d,
  output logic        ir_wena,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        kill_q, kill_d;
  logic [31:0] kill_pc_q, kill_pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] ir_d_q, ir_d_d;
  logic        ir_wena_q, ir_wena_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_next;

  assign pc_next  = fetch_pc_q + PC_STEP;
  assign mem_req  = (state_q == REQ);
  assign mem_addr = fetch_pc_q;
  assign ir_d     = ir_d_q;
  assign ir_wena  = ir_wena_q;
  assign pc       = pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      kill_q     <= 1'b0;
      kill_pc_q  <= '0;
      buf_q      <= '0;
      buf_pc_q   <= '0;
      ir_d_q     <= '0;
      ir_wena_q  <= 1'b0;
      pc_q       <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      kill_q     <= kill_d;
      kill_pc_q  <= kill_pc_d;
      buf_q      <= buf_d;
      buf_pc_q   <= buf_pc_d;
      ir_d_q     <= ir_d_d;
      ir_wena_q  <= ir_wena_d;
      pc_q       <= pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    kill_pc_d  = kill_pc_q;
    buf_d      = buf_q;
    buf_pc_d   = buf_pc_q;
    ir_d_d     = ir_d_q;
    ir_wena_d  = 1'b0;
    pc_d       = pc_q;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end
      end
      REQ: begin
        if (!mem_ack) begin
          // Address must stay put until ack; remember the target instead.
          if (redirect) begin
            kill_d    = 1'b1;
            kill_pc_d = redirect_pc;
          end
        end else if (redirect || kill_q) begin
          fetch_pc_d = redirect ? redirect_pc : kill_pc_q;
          kill_d     = 1'b0;
        end else if (!stall) begin
          ir_d_d     = mem_rdata;
          pc_d       = fetch_pc_q;
          ir_wena_d  = 1'b1;
          fetch_pc_d = pc_next;
        end else begin
          buf_d      = mem_rdata;
          buf_pc_d   = fetch_pc_q;
          fetch_pc_d = pc_next;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = REQ;
        end else if (!stall) begin
          ir_d_d    = buf_q;
          pc_d      = buf_pc_q;
          ir_wena_d = 1'b1;
          state_d   = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory responder with variable
// latency, expected IR deliveries checked by a scoreboard monitor.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] ir_d;
  logic        ir_wena;
  logic [31:0] pc;

  int   n_chk = 0;
  int   n_fail = 0;
  int   lat = 0;
  int   cnt = 0;
  logic ack_force = 1'b0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ir_d        (ir_d),
    .ir_wena     (ir_wena),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    exp_q.push_back('{pc: a, data: word(a)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: acks after lat idle cycles of an outstanding request.
  always @(negedge clk) begin
    mem_rdata = word(mem_addr);
    if (mem_req) begin
      if (cnt >= lat) begin
        mem_ack = 1'b1;
        cnt = 0;
      end else begin
        mem_ack = 1'b0;
        cnt++;
      end
    end else begin
      mem_ack = ack_force;
      cnt = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ir_wena) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_wena: got pc %h ir_d %h expected none",
                 pc, ir_d);
      end else begin
        e = exp_q.pop_front();
        chk("ir_pc", pc, e.pc);
        chk("ir_data", ir_d, e.data);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    stall = 1'b0;
    lat = 0;
    tick();
    tick();
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_ir_d", ir_d, 32'h0);
    chk("rst_wena", {31'd0, ir_wena}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("drain", exp_q.size(), 32'd0);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Sequential fetch, same-cycle ack
    do_reset();
    push(32'h0);
    push(32'h4);
    push(32'h8);
    for (int i = 0; i < 4; i++) begin
      chk("seq_req", {31'd0, mem_req}, 32'd1);
      chk("seq_addr", mem_addr, 32'(4 * i));
      chk("seq_wena", {31'd0, ir_wena}, (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) chk("seq_pc", pc, 32'(4 * (i - 1)));
      if (i < 3) tick();
    end

    // Stall on ack at 8, release after 3 cycles
    do_reset();
    push(32'h0);
    push(32'h4);
    push(32'h8);
    tick();
    tick();
    chk("stl_addr", mem_addr, 32'h8);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stl_hold_req", {31'd0, mem_req}, 32'd0);
      chk("stl_hold_wena", {31'd0, ir_wena}, 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("stl_wena", {31'd0, ir_wena}, 32'd1);
    chk("stl_pc", pc, 32'h8);
    chk("stl_req", {31'd0, mem_req}, 32'd1);
    chk("stl_next", mem_addr, 32'hC);

    // Redirect while request to 8 waits for ack
    do_reset();
    push(32'h0);
    push(32'h4);
    push(32'h100);
    tick();
    tick();
    chk("kil_addr0", mem_addr, 32'h8);
    lat = 2;
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick();
    chk("kil_req1", {31'd0, mem_req}, 32'd1);
    chk("kil_addr1", mem_addr, 32'h8);
    redirect = 1'b0;
    tick();
    chk("kil_addr2", mem_addr, 32'h8);
    chk("kil_wena2", {31'd0, ir_wena}, 32'd0);
    lat = 0;
    tick();
    chk("kil_tgt", mem_addr, 32'h100);
    chk("kil_drop", {31'd0, ir_wena}, 32'd0);
    tick();
    chk("kil_wena", {31'd0, ir_wena}, 32'd1);
    chk("kil_pc", pc, 32'h100);

    // Redirect and stall together in HOLD
    do_reset();
    push(32'h0);
    push(32'h200);
    tick();
    stall = 1'b1;
    tick();
    chk("hrd_req", {31'd0, mem_req}, 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick();
    chk("hrd_req2", {31'd0, mem_req}, 32'd1);
    chk("hrd_addr", mem_addr, 32'h200);
    chk("hrd_wena", {31'd0, ir_wena}, 32'd0);
    redirect = 1'b0;
    stall = 1'b0;
    tick();
    chk("hrd_pc", pc, 32'h200);

    // Address wrap
    do_reset();
    push(32'hFFFF_FFFC);
    push(32'h0);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    chk("wrp_addr0", mem_addr, 32'hFFFF_FFFC);
    chk("wrp_wena0", {31'd0, ir_wena}, 32'd0);
    redirect = 1'b0;
    tick();
    chk("wrp_addr1", mem_addr, 32'h0);
    chk("wrp_pc0", pc, 32'hFFFF_FFFC);
    tick();
    chk("wrp_addr2", mem_addr, 32'h4);
    chk("wrp_pc1", pc, 32'h0);

    // Redirect ignored during reset, honoured in IDLE
    rst = 1'b1;
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h40;
    tick();
    chk("idl_rst_addr", mem_addr, 32'h0);
    chk("idl_rst_req", {31'd0, mem_req}, 32'd0);
    rst = 1'b0;
    tick();
    chk("idl_addr", mem_addr, 32'h40);
    redirect = 1'b0;
    push(32'h40);
    tick();
    chk("idl_pc", pc, 32'h40);

    // Reset mid-request, late ack ignored
    do_reset();
    push(32'h0);
    push(32'h4);
    tick();
    tick();
    lat = 3;
    tick();
    chk("mid_req", {31'd0, mem_req}, 32'd1);
    chk("mid_addr", mem_addr, 32'h8);
    chk("mid_pc", pc, 32'h4);
    rst = 1'b1;
    tick();
    chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
    chk("mid_rst_wena", {31'd0, ir_wena}, 32'd0);
    chk("mid_rst_ir", ir_d, 32'h0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    rst = 1'b0;
    ack_force = 1'b1;
    tick();
    chk("mid_re_req", {31'd0, mem_req}, 32'd1);
    chk("mid_re_addr", mem_addr, 32'h0);
    chk("mid_re_wena", {31'd0, ir_wena}, 32'd0);
    ack_force = 1'b0;
    lat = 0;
    push(32'h0);
    tick();
    chk("mid_re_pc", pc, 32'h0);

    rst = 1'b1;
    tick();
    tick();
    chk("final_drain", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
